// File: rtl/router_tx_buf_if.sv
// Core/link handshake bundle for the transmit buffer.
// The slave modport is the buffer side, and the master modport is the core/link side that drives it.
interface router_tx_buf_if;
    logic        d_vld;
    logic [63:0] d_dat;
    logic        d_bp;
    logic        q_vld;
    logic [63:0] q_dat;
    logic        q_bp;
    logic        coll;
    logic        drop;
    logic        late_coll;
    logic [3:0]  retry_cnt;

    modport master (
        output d_vld, d_dat, q_bp, coll,
        input  d_bp, q_vld, q_dat, drop, late_coll, retry_cnt
    );

    modport slave (
        input  d_vld, d_dat, q_bp, coll,
        output d_bp, q_vld, q_dat, drop, late_coll, retry_cnt
    );
endinterface

// File: rtl/router_tx_buf.sv
// Tx packet buffer: an FWFT FIFO to the link with header replay on an early collision. A written word can reach Q one cycle later.
// Link backpressure (q_bp) stalls Q, and the core sees almost-full on d_bp. The FIFO accepts writes regardless of d_bp and loses them when it is full.
module router_tx_buf #(
    parameter int FIFO_DEPTH   = 512,
    parameter int AFULL_MARGIN = 16,
    parameter int BUP_DEPTH    = 16,
    parameter int BACKOFF_CYC  = 8,
    parameter int MAX_RETRY    = 7
) (
    input  logic           clk_i,
    input  logic           rst_i,
    router_tx_buf_if.slave tx_io
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BUP_DEPTH);
    localparam int KW = BW + 1;
    localparam int CW = $clog2(MAX_RETRY * BACKOFF_CYC + 1);

    typedef struct packed {
        logic [7:0]  typ;
        logic [23:0] rsvd;
        logic [31:0] len;
    } hdr_t;

    typedef enum logic [1:0] {SEND, BACKOFF, REPLAY, DRAIN} state_e;

    logic [63:0]   fifo_mem [FIFO_DEPTH];
    logic [63:0]   bup_mem  [BUP_DEPTH];
    logic [PW:0]   wr_ptr_q, rd_ptr_q, fill;
    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [BW-1:0] ra_q, ra_d;
    logic [31:0]   rem_q, rem_d;
    logic [3:0]    retry_q, retry_d;
    logic [CW-1:0] boff_q, boff_d;
    logic          drop_q, drop_d, late_q, late_d;

    hdr_t head;
    logic empty, full, wr_en, pop, take, q_vld, last_word, in_window, coll_retry;

    assign fill      = wr_ptr_q - rd_ptr_q;
    assign empty     = (fill == '0);
    assign full      = (fill == (PW+1)'(FIFO_DEPTH));
    assign wr_en     = tx_io.d_vld & ~full;
    assign head      = fifo_mem[rd_ptr_q[PW-1:0]];
    // k_q saturates at BUP_DEPTH, so past the window only rem_q tracks the packet end
    assign last_word = (k_q == '0) ? (head.typ == 8'h01 || head.len == 32'd0)
                                   : (rem_q == 32'd1);

    assign q_vld      = ~tx_io.coll & ((state_q == SEND & ~empty) | (state_q == REPLAY));
    assign take       = q_vld & ~tx_io.q_bp;
    assign pop        = (state_q == SEND & take) | (state_q == DRAIN & ~empty);
    assign in_window  = (k_q < KW'(BUP_DEPTH)) & ~((k_q == '0) & empty);
    assign coll_retry = tx_io.coll & ((state_q == REPLAY) | (state_q == SEND & in_window));

    assign tx_io.d_bp      = (fill >= (PW+1)'(FIFO_DEPTH - AFULL_MARGIN));
    assign tx_io.q_vld     = q_vld;
    assign tx_io.q_dat     = (state_q == REPLAY) ? bup_mem[ra_q] : head;
    assign tx_io.drop      = drop_q;
    assign tx_io.late_coll = late_q;
    assign tx_io.retry_cnt = retry_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ra_d    = ra_q;
        rem_d   = rem_q;
        retry_d = retry_q;
        boff_d  = boff_q;
        drop_d  = 1'b0;
        late_d  = 1'b0;
        unique case (state_q)
            SEND: begin
                if (tx_io.coll) begin
                    late_d = (k_q >= KW'(BUP_DEPTH));
                end else if (take) begin
                    if (last_word) begin
                        k_d     = '0;
                        retry_d = '0;
                    end else begin
                        rem_d = (k_q == '0) ? head.len : rem_q - 32'd1;
                        if (k_q < KW'(BUP_DEPTH)) k_d = k_q + KW'(1);
                    end
                end
            end
            BACKOFF: begin
                if (boff_q <= CW'(1)) begin
                    state_d = (k_q == '0) ? SEND : REPLAY;
                    ra_d    = '0;
                end else begin
                    boff_d = boff_q - CW'(1);
                end
            end
            REPLAY: begin
                // k_q holds the replay length S; the next word after it comes from the FIFO
                if (take) begin
                    if ({1'b0, ra_q} + KW'(1) == k_q) state_d = SEND;
                    else                              ra_d    = ra_q + BW'(1);
                end
            end
            DRAIN: begin
                if (~empty) begin
                    if (last_word) begin
                        drop_d  = 1'b1;
                        k_d     = '0;
                        retry_d = '0;
                        state_d = SEND;
                    end else begin
                        rem_d = (k_q == '0) ? head.len : rem_q - 32'd1;
                        if (k_q < KW'(BUP_DEPTH)) k_d = k_q + KW'(1);
                    end
                end
            end
        endcase
        if (coll_retry) begin
            if (retry_q == 4'(MAX_RETRY)) begin
                state_d = DRAIN;
            end else begin
                retry_d = retry_q + 4'd1;
                boff_d  = CW'((int'(retry_q) + 1) * BACKOFF_CYC);
                state_d = BACKOFF;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= SEND;
            k_q      <= '0;
            ra_q     <= '0;
            rem_q    <= '0;
            retry_q  <= '0;
            boff_q   <= '0;
            drop_q   <= 1'b0;
            late_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + (PW+1)'(wr_en);
            rd_ptr_q <= rd_ptr_q + (PW+1)'(pop);
            state_q  <= state_d;
            k_q      <= k_d;
            ra_q     <= ra_d;
            rem_q    <= rem_d;
            retry_q  <= retry_d;
            boff_q   <= boff_d;
            drop_q   <= drop_d;
            late_q   <= late_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) fifo_mem[wr_ptr_q[PW-1:0]] <= tx_io.d_dat;
        if (state_q == SEND && take && k_q < KW'(BUP_DEPTH)) bup_mem[k_q[BW-1:0]] <= head;
    end
endmodule
